// File: rtl/pcie_cv_reset_pkg.sv
// Shared types and constants for the Cyclone V PCIe HIP reset sequencer.
//   seq_state_t     : sequencer state codes (also exported on the debug port)
//   RESET_COUNT_MAX : saturation value of the RUN-entry counter
//   cnt_w_ok()      : true when a CNT_W-bit timer can hold every cycle limit
package pcie_cv_reset_pkg;

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    WAIT_HIP  = 3'd2,
    RUN       = 3'd3,
    ERROR     = 3'd4
  } seq_state_t;

  localparam int unsigned RESET_COUNT_MAX = 255;

  // Width check used by the top to reject a timer too narrow for its limits.
  function automatic bit cnt_w_ok(input int unsigned cnt_w,
                                  input int unsigned hold_cycles,
                                  input int unsigned lock_timeout,
                                  input int unsigned hip_timeout);
    longint unsigned lim;
    longint unsigned need;
    if (cnt_w >= 63) return 1'b1;
    lim  = (64'd1 << cnt_w) - 64'd1;
    need = 64'(hold_cycles);
    if (64'(lock_timeout) > need) need = 64'(lock_timeout);
    if (64'(hip_timeout) > need) need = 64'(hip_timeout);
    return (need <= lim);
  endfunction

endpackage

// File: rtl/pcie_cv_bit_sync.sv
// Multi-flop synchronizer for a single asynchronous control bit.
//   clk   : destination clock
//   rst_n : async active-low reset, clears every stage to 0
//   d     : asynchronous input
//   q     : synchronized output (last stage of the chain)
module pcie_cv_bit_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift chain; bit 0 is the metastability-catching stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pcie_cv_hip_reset_seq.sv
// Power-on / PERST# reset sequencer for the Cyclone V PCIe hard IP.
// Qualifies PERST# and the fixedclk lock, releases the HIP in order and
// holds the application in reset until the HIP reports nreset_status high.
//   clk_clk          : 100 MHz system clock
//   reset_reset_n    : async active-low reset
//   perst_n_pin      : slot PERST#, async, active-low
//   fixedclk_locked  : reconfig fixedclk lock, async
//   hip_reset_n_stat : HIP nreset_status, async, active-low
//   hip_npor         : HIP npor conduit, active-low
//   hip_pin_perst    : HIP pin_perst conduit, active-low
//   app_reset_n      : application reset, active-low
//   link_timeout     : sticky error flag, cleared only by PERST#
//   seq_state        : current state code (debug)
//   reset_count      : saturating count of RUN entries
module pcie_cv_hip_reset_seq
  import pcie_cv_reset_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned HOLD_CYCLES  = 1000,
  parameter int unsigned LOCK_TIMEOUT = 100000,
  parameter int unsigned HIP_TIMEOUT  = 1000000,
  parameter int unsigned CNT_W        = 24
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       perst_n_pin,
  input  logic       fixedclk_locked,
  input  logic       hip_reset_n_stat,
  output logic       hip_npor,
  output logic       hip_pin_perst,
  output logic       app_reset_n,
  output logic       link_timeout,
  output logic [2:0] seq_state,
  output logic [7:0] reset_count
);

  localparam bit CNT_W_OK = cnt_w_ok(CNT_W, HOLD_CYCLES, LOCK_TIMEOUT, HIP_TIMEOUT);

  if (!CNT_W_OK || (SYNC_STAGES < 2)) begin : g_bad_param
    $error("pcie_cv_hip_reset_seq: CNT_W too narrow or SYNC_STAGES < 2");
  end

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] HIP_LAST  = CNT_W'(HIP_TIMEOUT - 1);

  logic perst_s, lock_s, stat_s;

  seq_state_t       state_q, state_nxt;
  logic [CNT_W-1:0] timer_q, timer_nxt;
  logic             npor_nxt, pin_perst_nxt, app_nxt, timeout_nxt;
  logic [7:0]       count_nxt;

  // Input synchronizers
  pcie_cv_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_perst (
    .clk(clk_clk), .rst_n(reset_reset_n), .d(perst_n_pin), .q(perst_s)
  );
  pcie_cv_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_lock (
    .clk(clk_clk), .rst_n(reset_reset_n), .d(fixedclk_locked), .q(lock_s)
  );
  pcie_cv_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_stat (
    .clk(clk_clk), .rst_n(reset_reset_n), .d(hip_reset_n_stat), .q(stat_s)
  );

  // State register plus registered outputs decoded from the next state
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q       <= HOLD;
      timer_q       <= '0;
      hip_npor      <= 1'b0;
      hip_pin_perst <= 1'b0;
      app_reset_n   <= 1'b0;
      link_timeout  <= 1'b0;
      reset_count   <= '0;
    end else begin
      state_q       <= state_nxt;
      timer_q       <= timer_nxt;
      hip_npor      <= npor_nxt;
      hip_pin_perst <= pin_perst_nxt;
      app_reset_n   <= app_nxt;
      link_timeout  <= timeout_nxt;
      reset_count   <= count_nxt;
    end
  end

  assign seq_state = state_q;

  // Next-state, timer and output decode
  always_comb begin
    state_nxt     = state_q;
    timer_nxt     = '0;
    npor_nxt      = 1'b0;
    pin_perst_nxt = 1'b0;
    app_nxt       = 1'b0;
    timeout_nxt   = 1'b0;
    count_nxt     = reset_count;

    case (state_q)
      HOLD: begin
        if (timer_q == HOLD_LAST) state_nxt = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s)                      state_nxt = WAIT_HIP;
        else if (timer_q == LOCK_LAST)   state_nxt = ERROR;
      end
      WAIT_HIP: begin
        if (stat_s)                      state_nxt = RUN;
        else if (!lock_s)                state_nxt = HOLD;
        else if (timer_q == HIP_LAST)    state_nxt = ERROR;
      end
      RUN: begin
        if (!lock_s || !stat_s) state_nxt = HOLD;
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = HOLD;
      end
    endcase

    // PERST# low overrides everything, including ERROR
    if (!perst_s) state_nxt = HOLD;

    // Timer runs only while staying in a timed state; it saturates rather than wraps
    if (perst_s && (state_nxt == state_q) &&
        ((state_q == HOLD) || (state_q == WAIT_LOCK) || (state_q == WAIT_HIP))) begin
      timer_nxt = (&timer_q) ? timer_q : timer_q + CNT_W'(1);
    end

    if ((state_q == WAIT_HIP) && (state_nxt == RUN) &&
        (reset_count != 8'(RESET_COUNT_MAX))) begin
      count_nxt = reset_count + 8'd1;
    end

    case (state_nxt)
      WAIT_LOCK: begin
        pin_perst_nxt = 1'b1;
      end
      WAIT_HIP: begin
        npor_nxt      = 1'b1;
        pin_perst_nxt = 1'b1;
      end
      RUN: begin
        npor_nxt      = 1'b1;
        pin_perst_nxt = 1'b1;
        app_nxt       = 1'b1;
      end
      ERROR: begin
        pin_perst_nxt = 1'b1;
        timeout_nxt   = 1'b1;
      end
      default: begin
        npor_nxt      = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pcie_cv_hip_reset_seq.sv
// Testbench for pcie_cv_hip_reset_seq: directed bring-up/fault scenarios and
// random input activity, checked by a timestamped scoreboard fed from a
// cycle-level reference model of the sequencing rules.
module tb_pcie_cv_hip_reset_seq;

  localparam int unsigned SYNC = 2;
  localparam int unsigned HOLD = 16;
  localparam int unsigned LOCK = 32;
  localparam int unsigned HIP  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       perst = 1'b0;
  logic       lock = 1'b0;
  logic       stat = 1'b0;
  logic       hip_npor, hip_pin_perst, app_reset_n, link_timeout;
  logic [2:0] seq_state;
  logic [7:0] reset_count;

  pcie_cv_hip_reset_seq #(
    .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .LOCK_TIMEOUT(LOCK),
    .HIP_TIMEOUT(HIP), .CNT_W(24)
  ) dut (
    .clk_clk(clk), .reset_reset_n(rst_n), .perst_n_pin(perst),
    .fixedclk_locked(lock), .hip_reset_n_stat(stat),
    .hip_npor(hip_npor), .hip_pin_perst(hip_pin_perst),
    .app_reset_n(app_reset_n), .link_timeout(link_timeout),
    .seq_state(seq_state), .reset_count(reset_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       npor;
    logic       pperst;
    logic       app;
    logic       tmo;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    int unsigned stamp;
    obs_t        val;
  } evt_t;

  evt_t        sb[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  // Synchronizers are modelled as plain delay queues; timers as the edge
  // index at which the current count window opened.
  int          m_st = 0;
  int unsigned m_cnt = 0;
  int unsigned m_start = 0;
  bit          m_fresh = 1'b1;
  bit          pq[$], lq[$], sq[$];
  obs_t        last_exp = '0;

  function automatic obs_t exp_of(input int st, input int unsigned cnt);
    obs_t e;
    e = '0;
    e.st  = 3'(st);
    e.cnt = 8'(cnt);
    case (st)
      1: e.pperst = 1'b1;
      2: begin e.npor = 1'b1; e.pperst = 1'b1; end
      3: begin e.npor = 1'b1; e.pperst = 1'b1; e.app = 1'b1; end
      4: begin e.pperst = 1'b1; e.tmo = 1'b1; end
      default: e.npor = 1'b0;
    endcase
    return e;
  endfunction

  task automatic push_if_changed(input int unsigned stamp);
    obs_t e;
    evt_t ev;
    e = exp_of(m_st, m_cnt);
    if (e != last_exp) begin
      ev.stamp = stamp;
      ev.val   = e;
      sb.push_back(ev);
      last_exp = e;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    int unsigned n, el;
    bit p, l, s;
    int nx;
    if (!rst_n) begin
      m_st = 0;
      m_cnt = 0;
      m_fresh = 1'b1;
      pq.delete(); lq.delete(); sq.delete();
      for (int i = 0; i < int'(SYNC); i++) begin
        pq.push_back(1'b0); lq.push_back(1'b0); sq.push_back(1'b0);
      end
      push_if_changed(cyc);
    end else begin
      n = cyc + 1;
      p = pq.pop_front(); pq.push_back(perst);
      l = lq.pop_front(); lq.push_back(lock);
      s = sq.pop_front(); sq.push_back(stat);
      if (m_fresh) begin
        m_start = n;
        m_fresh = 1'b0;
      end
      el = n - m_start;
      nx = m_st;
      case (m_st)
        0: if (el == HOLD - 1) nx = 1;
        1: if (l) nx = 2; else if (el == LOCK - 1) nx = 4;
        2: if (s) nx = 3; else if (!l) nx = 0; else if (el == HIP - 1) nx = 4;
        3: if (!l || !s) nx = 0;
        default: nx = m_st;
      endcase
      if (!p) nx = 0;
      if (m_st == 2 && nx == 3 && m_cnt < 255) m_cnt++;
      if (!p || nx != m_st) m_start = n + 1;
      m_st = nx;
      push_if_changed(n);
    end
  end

  // ---------------- monitor ----------------
  function automatic obs_t cur_obs();
    return {seq_state, hip_npor, hip_pin_perst, app_reset_n, link_timeout, reset_count};
  endfunction

  obs_t last_obs = '0;

  always @(negedge clk) begin
    obs_t o;
    evt_t e;
    o = cur_obs();
    if (o !== last_obs) begin
      last_obs = o;
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected cyc=%0d got=%h required=no change", cyc, o);
      end else begin
        e = sb.pop_front();
        if (e.val !== o || e.stamp != cyc) begin
          fails++;
          $display("FAIL sb_event got cyc=%0d val=%h required cyc=%0d val=%h",
                   cyc, o, e.stamp, e.val);
        end
      end
    end
    while (sb.size() > 0 && sb[0].stamp < cyc) begin
      e = sb.pop_front();
      tests++;
      fails++;
      $display("FAIL sb_missing got no change by cyc=%0d required cyc=%0d val=%h",
               cyc, e.stamp, e.val);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    tests++;
    if (got !== req) begin
      fails++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return hip_npor;
      1:       return app_reset_n;
      default: return link_timeout;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input logic val, input int unsigned bound,
                          input string name, output int unsigned at);
    at = 0;
    tests++;
    for (int unsigned i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sig_of(sel) === val) begin
        at = cyc;
        return;
      end
    end
    fails++;
    $display("FAIL %s got=no edge in %0d cycles required=%0b", name, bound, val);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned t0, at;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(cur_obs()), 32'd0);
    rst_n = 1'b1;

    // 1. Normal bring-up
    lock = 1'b1; stat = 1'b0;
    repeat (4) @(negedge clk);
    t0 = cyc; perst = 1'b1;
    wait_sig(0, 1'b1, 40, "npor_rise", at);
    check("npor_latency", at - t0, HOLD + SYNC + 1);
    check("pin_perst_up", 32'(hip_pin_perst), 32'd1);
    check("app_held", 32'(app_reset_n), 32'd0);
    repeat (10) @(negedge clk);
    t0 = cyc; stat = 1'b1;
    wait_sig(1, 1'b1, 10, "app_rise", at);
    check("app_latency", at - t0, SYNC + 1);
    check("count_first", 32'(reset_count), 32'd1);
    check("state_run", 32'(seq_state), 32'd3);

    // 2. One-cycle PERST# drop in RUN
    t0 = cyc; perst = 1'b0;
    @(negedge clk); perst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("drop_app", 32'(app_reset_n), 32'd0);
    check("drop_npor", 32'(hip_npor), 32'd0);
    check("drop_state", 32'(seq_state), 32'd0);
    wait_sig(0, 1'b1, 40, "npor_rerise", at);
    check("restart_latency", at - t0, HOLD + SYNC + 2);
    wait_sig(1, 1'b1, 10, "app_rerise", at);
    check("count_second", 32'(reset_count), 32'd2);

    // 3. Lock timeout
    lock = 1'b0; stat = 1'b0; perst = 1'b0;
    repeat (3) @(negedge clk);
    t0 = cyc; perst = 1'b1;
    wait_sig(2, 1'b1, HOLD + LOCK + 10, "lock_tmo", at);
    check("lock_tmo_latency", at - t0, HOLD + SYNC + LOCK);
    check("lock_tmo_npor", 32'(hip_npor), 32'd0);
    check("lock_tmo_state", 32'(seq_state), 32'd4);
    perst = 1'b0;
    @(negedge clk); perst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("tmo_clear", 32'(link_timeout), 32'd0);
    check("tmo_exit_state", 32'(seq_state), 32'd0);

    // 4. HIP timeout, then lost lock in WAIT_HIP
    lock = 1'b1; stat = 1'b0; perst = 1'b0;
    repeat (3) @(negedge clk);
    t0 = cyc; perst = 1'b1;
    wait_sig(2, 1'b1, HOLD + HIP + 20, "hip_tmo", at);
    check("hip_tmo_latency", at - t0, HOLD + SYNC + 1 + HIP);
    check("hip_tmo_npor", 32'(hip_npor), 32'd0);
    perst = 1'b0;
    repeat (3) @(negedge clk);
    perst = 1'b1;
    wait_sig(0, 1'b1, 40, "npor_lostlock", at);
    repeat (2) @(negedge clk);
    lock = 1'b0;
    repeat (4) @(negedge clk);
    check("lostlock_state", 32'(seq_state), 32'd0);
    check("lostlock_tmo", 32'(link_timeout), 32'd0);
    check("lostlock_npor", 32'(hip_npor), 32'd0);

    // 5. Async reset mid-WAIT_HIP
    lock = 1'b1; stat = 1'b0; perst = 1'b0;
    repeat (3) @(negedge clk);
    perst = 1'b1;
    wait_sig(0, 1'b1, 40, "npor_pre_rst", at);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'(cur_obs()), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // 6. Counter saturation
    stat = 1'b1;
    wait_sig(1, 1'b1, 40, "sat_first_run", at);
    for (int k = 0; k < 260; k++) begin
      perst = 1'b0;
      @(negedge clk); perst = 1'b1;
      wait_sig(1, 1'b0, 6, "sat_app_fall", at);
      wait_sig(1, 1'b1, 40, "sat_app_rise", at);
    end
    check("count_saturated", 32'(reset_count), 32'd255);

    // 7. Random input activity
    for (int k = 0; k < 60; k++) begin
      perst = ($urandom_range(0, 7) != 0);
      lock  = ($urandom_range(0, 4) != 0);
      stat  = ($urandom_range(0, 2) != 0);
      repeat ($urandom_range(1, 50)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_drain got=%0d pending required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
